// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan decoder.
//   SEG_0..SEG_9 : active-high segment patterns {a,b,c,d,e,f,g}, a = bit 6
//   SEG_BLANK    : all segments off
//   BCD_INVALID  : nibble reported for any non-digit pattern
//   digit_t      : decoder result {valid, bcd}
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;

   localparam logic [6:0] SEG_BLANK   = 7'b0000000;
   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef struct packed {
      logic       valid;
      logic [3:0] bcd;
   } digit_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: combinational 7-segment pattern to BCD decoder.
//   seg   in  7   segment pattern {a,b,c,d,e,f,g}, active-high
//   digit out 5   {valid, bcd}; unknown patterns give valid=0, bcd=4'hF
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output digit_t     digit
);

   // Map each standard digit pattern back to its value; everything else is invalid.
   always_comb begin
      digit.valid = 1'b1;
      digit.bcd   = BCD_INVALID;
      case (seg)
         SEG_0:   digit.bcd = 4'd0;
         SEG_1:   digit.bcd = 4'd1;
         SEG_2:   digit.bcd = 4'd2;
         SEG_3:   digit.bcd = 4'd3;
         SEG_4:   digit.bcd = 4'd4;
         SEG_5:   digit.bcd = 4'd5;
         SEG_6:   digit.bcd = 4'd6;
         SEG_7:   digit.bcd = 4'd7;
         SEG_8:   digit.bcd = 4'd8;
         SEG_9:   digit.bcd = 4'd9;
         default: begin
            digit.valid = 1'b0;
            digit.bcd   = BCD_INVALID;
         end
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: receives a multiplexed 7-segment bus and rebuilds the BCD word.
//   clk, rst   single clock, asynchronous active-high reset
//   seg_in     segment lines {a..g}, a = bit 6
//   an_in      one-hot digit enables, an_in[i] -> nibble i
//   out_ready  consumer accept strobe
//   clear_ovf  synchronous clear of the sticky overflow flag
//   out_valid  bcd_out/frame_err hold a complete frame
//   bcd_out    assembled BCD word (4'hF for undecodable digits)
//   frame_err  at least one digit of the frame was undecodable
//   overflow   sticky: a frame completed while the previous one was still held
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   input  logic                    out_ready,
   input  logic                    clear_ovf,
   output logic                    out_valid,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    frame_err,
   output logic                    overflow
);

   localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SMP_W = NUM_DIGITS + 7;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   // The count holds (identical samples - 1), so the last required sample arrives
   // while the registered count equals STABLE_CYCLES-2.
   localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);

   logic [SMP_W-1:0]                sample_s;
   logic [SMP_W-1:0]                sample_r;
   logic [CNT_W-1:0]                cnt_r;
   logic                            found_s;
   logic                            multi_s;
   logic [IDX_W-1:0]                idx_s;
   logic                            match_s;
   logic                            capture_s;
   logic                            frame_done_s;
   logic                            load_s;
   digit_t                          digit_s;
   logic [NUM_DIGITS-1:0]           mask_r;
   logic [NUM_DIGITS-1:0]           err_r;
   logic [NUM_DIGITS-1:0][3:0]      data_r;

   assign sample_s = {an_in, seg_in};

   seg7_digit_decode u_decode (
      .seg   (seg_in),
      .digit (digit_s)
   );

   // One-hot check and position encoder for the digit enables.
   always_comb begin
      found_s = 1'b0;
      multi_s = 1'b0;
      idx_s   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (an_in[i]) begin
            if (found_s) begin
               multi_s = 1'b1;
            end else begin
               multi_s = multi_s;
            end
            found_s = 1'b1;
            idx_s   = IDX_W'(i);
         end else begin
            found_s = found_s;
         end
      end
   end

   assign match_s      = (sample_s == sample_r) && found_s && !multi_s;
   // Exact compare (not >=) so a long stable run captures only once; the
   // saturating counter never returns to this value without a change.
   assign capture_s    = match_s && (cnt_r == CNT_FIRE);
   assign frame_done_s = &mask_r;
   assign load_s       = frame_done_s && (!out_valid || out_ready);

   // Input sample register and saturating stability counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_r <= '0;
         cnt_r    <= '0;
      end else begin
         sample_r <= sample_s;
         if (match_s) begin
            if (cnt_r != CNT_MAX) begin
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               cnt_r <= cnt_r;
            end
         end else begin
            cnt_r <= '0;
         end
      end
   end

   // Frame accumulators: a completed frame empties them; a capture fills one slot
   // (latest capture of a slot wins).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_r <= '0;
         err_r  <= '0;
         data_r <= '0;
      end else begin
         if (frame_done_s) begin
            mask_r <= '0;
            err_r  <= '0;
         end else begin
            mask_r <= mask_r;
            err_r  <= err_r;
         end
         if (capture_s) begin
            mask_r[idx_s] <= 1'b1;
            err_r[idx_s]  <= ~digit_s.valid;
            data_r[idx_s] <= digit_s.bcd;
         end else begin
            data_r <= data_r;
         end
      end
   end

   // Output register with valid/ready; accept and reload in one cycle keeps valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         bcd_out   <= '0;
         frame_err <= 1'b0;
      end else if (load_s) begin
         out_valid <= 1'b1;
         bcd_out   <= data_r;
         frame_err <= |err_r;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

   // Sticky overflow: a dropped frame beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (frame_done_s && !load_s) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end else begin
         overflow <= overflow;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed self-checking bench for seg7_scan_decoder.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   logic        clk;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic        out_ready;
   logic        clear_ovf;
   logic        out_valid;
   logic [15:0] bcd_out;
   logic        frame_err;
   logic        overflow;

   int          errors;
   int          checks;
   int          acc_cnt;
   int          valid_cycles;
   logic [15:0] acc_bcd;
   logic        acc_err;

   seg7_scan_decoder #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .an_in     (an_in),
      .out_ready (out_ready),
      .clear_ovf (clear_ovf),
      .out_valid (out_valid),
      .bcd_out   (bcd_out),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every accepted frame and every cycle with out_valid high.
   always @(negedge clk) begin
      if (out_valid === 1'b1) valid_cycles++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         acc_cnt++;
         acc_bcd = bcd_out;
         acc_err = frame_err;
      end
   end

   // Present {an,seg} for n rising edges; returns 2 ns after the last one.
   task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
      an_in  = an;
      seg_in = sg;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic scan_frame(input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0);
      drive(4'b1000, s3, 4);
      drive(4'b0100, s2, 4);
      drive(4'b0010, s1, 4);
      drive(4'b0001, s0, 4);
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      an_in     = 4'($urandom);
      seg_in    = 7'($urandom);
      out_ready = 1'($urandom);
      clear_ovf = 1'($urandom);
      repeat (3) @(posedge clk);
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h want 0000", bcd_out); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      #1 rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL deassert_valid: got %b want 0", out_valid); end
      checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL deassert_bcd: got %h want 0000", bcd_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL deassert_ovf: got %b want 0", overflow); end
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      clear_ovf = 1'b0;
      drive(4'b0000, SEG_BLANK, 4);
   endtask

   task automatic test_basic_frame;
      int a0;
      a0 = acc_cnt;
      out_ready = 1'b1;
      scan_frame(SEG_1, SEG_2, SEG_3, SEG_4);
      drive(4'b0000, SEG_BLANK, 4);
      checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL basic_count: got %0d frames want 1", acc_cnt - a0); end
      checks++; if (acc_bcd !== 16'h1234) begin errors++; $display("FAIL basic_bcd: got %h want 1234", acc_bcd); end
      checks++; if (acc_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", acc_err); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_glitch;
      int v0;
      v0 = valid_cycles;
      for (int i = 0; i < 12; i++) begin
         drive(4'b0001 << (i % 4), (i % 2 == 0) ? SEG_1 : SEG_2, 2);
      end
      drive(4'b0011, SEG_3, 10);
      drive(4'b0000, SEG_BLANK, 3);
      checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL glitch_valid_cycles: got %0d want 0", valid_cycles - v0); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_invalid_digit;
      int a0;
      a0 = acc_cnt;
      scan_frame(SEG_5, SEG_BLANK, SEG_5, SEG_5);
      drive(4'b0000, SEG_BLANK, 4);
      checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL invalid_count: got %0d frames want 1", acc_cnt - a0); end
      checks++; if (acc_bcd !== 16'h5F55) begin errors++; $display("FAIL invalid_bcd: got %h want 5f55", acc_bcd); end
      checks++; if (acc_err !== 1'b1) begin errors++; $display("FAIL invalid_err: got %b want 1", acc_err); end
   endtask

   task automatic test_overflow;
      int a0;
      a0 = acc_cnt;
      out_ready = 1'b0;
      scan_frame(SEG_1, SEG_2, SEG_3, SEG_4);
      drive(4'b0000, SEG_BLANK, 2);
      scan_frame(SEG_5, SEG_6, SEG_7, SEG_8);
      drive(4'b0000, SEG_BLANK, 2);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid_held: got %b want 1", out_valid); end
      checks++; if (bcd_out !== 16'h1234) begin errors++; $display("FAIL ovf_bcd_held: got %h want 1234", bcd_out); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      clear_ovf = 1'b1;
      drive(4'b0000, SEG_BLANK, 1);
      clear_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
      out_ready = 1'b1;
      drive(4'b0000, SEG_BLANK, 2);
      checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL ovf_accept_count: got %0d want 1", acc_cnt - a0); end
      checks++; if (acc_bcd !== 16'h1234) begin errors++; $display("FAIL ovf_accept_bcd: got %h want 1234", acc_bcd); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_after_accept: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_frame;
      int a0;
      a0 = acc_cnt;
      out_ready = 1'b1;
      drive(4'b0010, SEG_3, 4);
      drive(4'b0001, SEG_4, 4);
      an_in  = 4'b0000;
      seg_in = SEG_BLANK;
      #1 rst = 1'b1;
      #3 rst = 1'b0;
      @(posedge clk);
      #2;
      // Without the reset the leftover slots would complete a 5634 frame early.
      scan_frame(SEG_5, SEG_6, SEG_7, SEG_8);
      drive(4'b0000, SEG_BLANK, 4);
      checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL midrst_count: got %0d frames want 1", acc_cnt - a0); end
      checks++; if (acc_bcd !== 16'h5678) begin errors++; $display("FAIL midrst_bcd: got %h want 5678", acc_bcd); end
      checks++; if (acc_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", acc_err); end
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      acc_cnt      = 0;
      valid_cycles = 0;
      acc_bcd      = 16'h0;
      acc_err      = 1'b0;
      test_reset();
      test_basic_frame();
      test_glitch();
      test_invalid_digit();
      test_overflow();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
